mgmt_data_channel_arbiter: RTL and testbench

//  Shares the single LTPI management data channel between NUM_REQ local requesters
//  (I2C bridge ports, mailbox, etc.). Round-robin grant, one outstanding transaction.

---
 rtl/mgmt_dc_arb_pkg.sv | 28 ++
 rtl/mgmt_dc_rr_arbiter.sv | 45 ++++
 rtl/mgmt_data_channel_arbiter.sv | 147 ++++++++++++++
 tb/tb_mgmt_data_channel_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_dc_arb_pkg.sv
// Shared types and the round-robin pick helper for the management data-channel arbiter.
package mgmt_dc_arb_pkg;

   localparam int unsigned MaxReq      = 8;
   localparam int unsigned DefaultTagW = 3;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, RETURN} arb_state_t;

   // One-hot grant: first set bit of req[n-1:0] at or above ptr, wrapping past n-1.
   function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                  input logic [2:0]        ptr,
                                                  input int unsigned       n);
      logic [MaxReq-1:0] grant;
      logic              found;
      int unsigned       idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MaxReq; i++) begin
         idx = (32'(ptr) + i) % n;
         if (i < n && !found && req[idx[2:0]]) begin
            grant[idx[2:0]] = 1'b1;
            found           = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/mgmt_dc_rr_arbiter.sv
// Round-robin requester pick plus the rotating priority pointer.
module mgmt_dc_rr_arbiter
   import mgmt_dc_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PtrW    = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               adv_i,
   input  logic [PtrW-1:0]    owner_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PtrW-1:0]    grant_idx_o
);

   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic [MaxReq-1:0] req_ext;
   logic [MaxReq-1:0] pick;

   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = req_i;
      pick                 = rr_pick(req_ext, 3'(ptr_q), NUM_REQ);
      grant_o              = pick[NUM_REQ-1:0];
      grant_idx_o          = '0;
      for (int unsigned i = 0; i < MaxReq; i++) begin
         if (pick[i]) grant_idx_o = PtrW'(i);
      end
   end

   // Priority moves to the requester just after the one that was served.
   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         ptr_d = (owner_i == PtrW'(NUM_REQ - 1)) ? '0 : owner_i + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mgmt_data_channel_arbiter.sv
// Shares the LTPI management data channel between NUM_REQ requesters, one transaction at a
// time, routing the tagged response (or a timeout / link-loss error) back to its owner.
module mgmt_data_channel_arbiter
   import mgmt_dc_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned PAYLOAD_W   = 32,
   parameter int unsigned TAG_W       = DefaultTagW,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         link_aligned,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [PAYLOAD_W-1:0]         rsp_payload,
   output logic                         rsp_error,
   output logic                         ch_tx_valid,
   input  logic                         ch_tx_ready,
   output logic [PAYLOAD_W-1:0]         ch_tx_payload,
   output logic [TAG_W-1:0]             ch_tx_tag,
   input  logic                         ch_rx_valid,
   input  logic [TAG_W-1:0]             ch_rx_tag,
   input  logic [PAYLOAD_W-1:0]         ch_rx_payload,
   output logic                         busy
);

   localparam int unsigned PtrW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

   arb_state_t           state_q, state_d;
   logic [PtrW-1:0]      owner_q, owner_d;
   logic [PAYLOAD_W-1:0] tx_payload_q, tx_payload_d;
   logic                 ch_tx_valid_q, ch_tx_valid_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [PAYLOAD_W-1:0] rsp_payload_q, rsp_payload_d;
   logic                 rsp_error_q, rsp_error_d;

   logic [NUM_REQ-1:0]   grant;
   logic [PtrW-1:0]      grant_idx;
   logic                 finish_err;

   mgmt_dc_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PtrW    (PtrW)
   ) u_rr_arbiter (
      .clk_i       (clk),
      .rst_i       (reset),
      .req_i       (req_valid),
      .adv_i       (state_q == RETURN),
      .owner_i     (owner_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      tx_payload_d  = tx_payload_q;
      ch_tx_valid_d = ch_tx_valid_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = '0;
      rsp_payload_d = rsp_payload_q;
      rsp_error_d   = rsp_error_q;
      req_ready     = '0;
      finish_err    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // reset gates the accept strobe so outputs read 0 while reset is held
            if (link_aligned && (|req_valid) && !reset) begin
               req_ready     = grant;
               owner_d       = grant_idx;
               tx_payload_d  = req_payload[grant_idx*PAYLOAD_W +: PAYLOAD_W];
               ch_tx_valid_d = 1'b1;
               state_d       = SEND;
            end
         end
         SEND: begin
            if (!link_aligned) begin
               finish_err = 1'b1;
            end else if (ch_tx_ready) begin
               ch_tx_valid_d = 1'b0;
               cnt_d         = '0;
               state_d       = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            cnt_d = cnt_q + 1'b1;
            if (!link_aligned) begin
               finish_err = 1'b1;
            end else if (ch_rx_valid && ch_rx_tag == TAG_W'(owner_q)) begin
               rsp_payload_d        = ch_rx_payload;
               rsp_error_d          = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = RETURN;
            end else if (cnt_d == CntW'(TIMEOUT_CYC - 1)) begin
               finish_err = 1'b1;
            end
         end
         RETURN: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (finish_err) begin
         ch_tx_valid_d        = 1'b0;
         rsp_payload_d        = '0;
         rsp_error_d          = 1'b1;
         rsp_valid_d[owner_q] = 1'b1;
         state_d              = RETURN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         tx_payload_q  <= '0;
         ch_tx_valid_q <= 1'b0;
         cnt_q         <= '0;
         rsp_valid_q   <= '0;
         rsp_payload_q <= '0;
         rsp_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         tx_payload_q  <= tx_payload_d;
         ch_tx_valid_q <= ch_tx_valid_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_payload_q <= rsp_payload_d;
         rsp_error_q   <= rsp_error_d;
      end
   end

   assign ch_tx_valid   = ch_tx_valid_q;
   assign ch_tx_payload = tx_payload_q;
   assign ch_tx_tag     = TAG_W'(owner_q);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_payload   = rsp_payload_q;
   assign rsp_error     = rsp_error_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mgmt_data_channel_arbiter.sv
// Scenario bench for mgmt_data_channel_arbiter against a round-robin / timeout reference model.
module tb_mgmt_data_channel_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned PW = 32;
   localparam int unsigned TW = 3;
   localparam int unsigned TO = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             link_aligned = 1'b1;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*PW-1:0] req_payload = '0;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    rsp_valid;
   logic [PW-1:0]    rsp_payload;
   logic             rsp_error;
   logic             ch_tx_valid;
   logic             ch_tx_ready = 1'b0;
   logic [PW-1:0]    ch_tx_payload;
   logic [TW-1:0]    ch_tx_tag;
   logic             ch_rx_valid = 1'b0;
   logic [TW-1:0]    ch_rx_tag = '0;
   logic [PW-1:0]    ch_rx_payload = '0;
   logic             busy;

   int checks    = 0;
   int failures  = 0;
   int model_ptr = 0;

   always #5 clk = ~clk;

   mgmt_data_channel_arbiter #(
      .NUM_REQ     (NR),
      .PAYLOAD_W   (PW),
      .TAG_W       (TW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .link_aligned  (link_aligned),
      .req_valid     (req_valid),
      .req_payload   (req_payload),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_payload   (rsp_payload),
      .rsp_error     (rsp_error),
      .ch_tx_valid   (ch_tx_valid),
      .ch_tx_ready   (ch_tx_ready),
      .ch_tx_payload (ch_tx_payload),
      .ch_tx_tag     (ch_tx_tag),
      .ch_rx_valid   (ch_rx_valid),
      .ch_rx_tag     (ch_rx_tag),
      .ch_rx_payload (ch_rx_payload),
      .busy          (busy)
   );

   // First requesting index at or after ptr, wrapping.
   function automatic int model_grant(input logic [NR-1:0] mask, input int ptr);
      for (int i = 0; i < NR; i++) begin
         if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] onehot(input int g);
      logic [NR-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      req_valid = '1;
      #1;
      checks++;
      if (req_ready !== '0) begin
         failures++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
      end
      checks++;
      if (rsp_valid !== '0 || rsp_error !== 1'b0 || rsp_payload !== '0) begin
         failures++;
         $display("FAIL reset_rsp: valid=%b err=%b pl=%h want 0", rsp_valid, rsp_error, rsp_payload);
      end
      checks++;
      if (ch_tx_valid !== 1'b0 || ch_tx_payload !== '0 || ch_tx_tag !== '0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_tx: v=%b pl=%h tag=%0d busy=%b want 0", ch_tx_valid, ch_tx_payload,
                  ch_tx_tag, busy);
      end
      req_valid = '0;
      @(negedge clk);
      reset     = 1'b0;
      model_ptr = 0;
   endtask

   task automatic test_round_robin();
      int            g;
      logic [PW-1:0] pl;
      @(negedge clk);
      for (int i = 0; i < NR; i++) req_payload[i*PW +: PW] = $urandom;
      ch_tx_ready = 1'b1;
      req_valid   = '1;
      for (int t = 0; t < 5; t++) begin
         g = model_grant('1, model_ptr);
         #1;
         checks++;
         if (req_ready !== onehot(g)) begin
            failures++; $display("FAIL rr_grant[%0d]: got %b want %b", t, req_ready, onehot(g));
         end
         @(negedge clk);
         #1;
         checks++;
         if (req_ready !== '0 || ch_tx_tag !== TW'(g) || ch_tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL rr_send[%0d]: ready=%b tag=%0d v=%b want 0/%0d/1", t, req_ready,
                     ch_tx_tag, ch_tx_valid, g);
         end
         @(negedge clk);
         pl            = $urandom;
         ch_rx_valid   = 1'b1;
         ch_rx_tag     = TW'(g);
         ch_rx_payload = pl;
         @(negedge clk);
         ch_rx_valid = 1'b0;
         #1;
         checks++;
         if (rsp_valid !== onehot(g) || rsp_payload !== pl || rsp_error !== 1'b0 ||
             req_ready !== '0) begin
            failures++;
            $display("FAIL rr_rsp[%0d]: valid=%b pl=%h err=%b ready=%b want %b/%h/0/0", t,
                     rsp_valid, rsp_payload, rsp_error, req_ready, onehot(g), pl);
         end
         model_ptr = (g + 1) % NR;
         @(negedge clk);
      end
      req_valid   = '0;
      ch_tx_ready = 1'b0;
   endtask

   task automatic test_single();
      int g;
      @(negedge clk);
      req_payload = '0;
      req_payload[0 +: PW] = 32'hA5A5_0001;
      req_valid = 4'b0001;
      #1;
      g = model_grant(4'b0001, model_ptr);
      checks++;
      if (req_ready !== onehot(g)) begin
         failures++; $display("FAIL single_ready: got %b want %b", req_ready, onehot(g));
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (ch_tx_valid !== 1'b1 || ch_tx_tag !== TW'(g) || ch_tx_payload !== 32'hA5A5_0001) begin
         failures++;
         $display("FAIL single_tx: v=%b tag=%0d pl=%h want 1/%0d/a5a50001", ch_tx_valid, ch_tx_tag,
                  ch_tx_payload, g);
      end
      @(negedge clk);
      ch_tx_ready = 1'b1;
      #1;
      checks++;
      if (ch_tx_valid !== 1'b1 || ch_tx_payload !== 32'hA5A5_0001 || busy !== 1'b1) begin
         failures++; $display("FAIL single_tx_hold: v=%b pl=%h busy=%b", ch_tx_valid,
                              ch_tx_payload, busy);
      end
      @(negedge clk);
      ch_tx_ready = 1'b0;
      #1;
      checks++;
      if (ch_tx_valid !== 1'b0) begin
         failures++; $display("FAIL single_tx_drop: v=%b want 0", ch_tx_valid);
      end
      repeat (9) @(negedge clk);
      ch_rx_valid   = 1'b1;
      ch_rx_tag     = '0;
      ch_rx_payload = 32'h0000_1234;
      @(negedge clk);
      ch_rx_valid = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_payload !== 32'h1234 || rsp_error !== 1'b0) begin
         failures++;
         $display("FAIL single_rsp: valid=%b pl=%h err=%b want 0001/1234/0", rsp_valid,
                  rsp_payload, rsp_error);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== '0 || rsp_payload !== 32'h1234 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_after: valid=%b pl=%h busy=%b want 0/1234/0", rsp_valid,
                  rsp_payload, busy);
      end
      model_ptr = (g + 1) % NR;
   endtask

   task automatic test_wrong_tag();
      int g;
      @(negedge clk);
      for (int i = 0; i < NR; i++) req_payload[i*PW +: PW] = $urandom;
      req_valid = 4'b0100;
      #1;
      g = model_grant(4'b0100, model_ptr);
      checks++;
      if (req_ready !== onehot(g)) begin
         failures++; $display("FAIL wt_ready: got %b want %b", req_ready, onehot(g));
      end
      @(negedge clk);
      req_valid     = '0;
      ch_rx_valid   = 1'b1;
      ch_rx_tag     = 3'd2;
      ch_rx_payload = 32'hDEAD;
      @(negedge clk);
      ch_rx_valid = 1'b0;
      ch_tx_ready = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== '0 || ch_tx_valid !== 1'b1) begin
         failures++; $display("FAIL wt_rx_in_send: rsp=%b txv=%b want 0/1", rsp_valid, ch_tx_valid);
      end
      @(negedge clk);
      ch_tx_ready   = 1'b0;
      ch_rx_valid   = 1'b1;
      ch_rx_tag     = 3'd1;
      ch_rx_payload = 32'h1111;
      @(negedge clk);
      ch_rx_valid = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b1) begin
         failures++; $display("FAIL wt_dropped: rsp=%b busy=%b want 0/1", rsp_valid, busy);
      end
      @(negedge clk);
      ch_rx_valid   = 1'b1;
      ch_rx_tag     = 3'd2;
      ch_rx_payload = 32'hBEEF;
      @(negedge clk);
      ch_rx_valid = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_payload !== 32'hBEEF || rsp_error !== 1'b0) begin
         failures++;
         $display("FAIL wt_rsp: valid=%b pl=%h err=%b want 0100/beef/0", rsp_valid, rsp_payload,
                  rsp_error);
      end
      model_ptr = (g + 1) % NR;
   endtask

   task automatic test_link_loss();
      int g;
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      g = model_grant(4'b0001, model_ptr);
      checks++;
      if (req_ready !== onehot(g)) begin
         failures++; $display("FAIL ll_ready: got %b want %b", req_ready, onehot(g));
      end
      @(negedge clk);
      req_valid   = '0;
      ch_tx_ready = 1'b1;
      @(negedge clk);
      ch_tx_ready  = 1'b0;
      link_aligned = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== onehot(g) || rsp_error !== 1'b1 || rsp_payload !== '0) begin
         failures++;
         $display("FAIL ll_wait_abort: valid=%b err=%b pl=%h want %b/1/0", rsp_valid, rsp_error,
                  rsp_payload, onehot(g));
      end
      model_ptr = (g + 1) % NR;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = '1;
         #1;
         checks++;
         if (req_ready !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL ll_no_grant[%0d]: ready=%b busy=%b want 0/0", k, req_ready,
                                 busy);
         end
      end
      req_valid    = '0;
      link_aligned = 1'b1;
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      g = model_grant(4'b0010, model_ptr);
      checks++;
      if (req_ready !== onehot(g)) begin
         failures++; $display("FAIL ll_ready2: got %b want %b", req_ready, onehot(g));
      end
      @(negedge clk);
      req_valid    = '0;
      link_aligned = 1'b0;
      #1;
      checks++;
      if (ch_tx_valid !== 1'b1) begin
         failures++; $display("FAIL ll_send_valid: got %b want 1", ch_tx_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== onehot(g) || rsp_error !== 1'b1 || ch_tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL ll_send_abort: valid=%b err=%b txv=%b want %b/1/0", rsp_valid, rsp_error,
                  ch_tx_valid, onehot(g));
      end
      link_aligned = 1'b1;
      model_ptr    = (g + 1) % NR;
   endtask

   task automatic test_reset_mid();
      int g;
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      g = model_grant(4'b0001, model_ptr);
      checks++;
      if (req_ready !== onehot(g)) begin
         failures++; $display("FAIL rm_ready: got %b want %b", req_ready, onehot(g));
      end
      @(negedge clk);
      req_valid   = '0;
      ch_tx_ready = 1'b1;
      @(negedge clk);
      ch_tx_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== '0 || rsp_payload !== '0 || rsp_error !== 1'b0 ||
          ch_tx_valid !== 1'b0 || ch_tx_payload !== '0 || ch_tx_tag !== '0) begin
         failures++;
         $display("FAIL rm_outputs: busy=%b rsp=%b pl=%h err=%b txv=%b txpl=%h tag=%0d want 0",
                  busy, rsp_valid, rsp_payload, rsp_error, ch_tx_valid, ch_tx_payload, ch_tx_tag);
      end
      @(negedge clk);
      reset     = 1'b0;
      model_ptr = 0;
      req_valid = '1;
      #1;
      g = model_grant('1, model_ptr);
      checks++;
      if (req_ready !== onehot(g)) begin
         failures++; $display("FAIL rm_ptr: got %b want %b", req_ready, onehot(g));
      end
      @(negedge clk);
      req_valid = '0;
      reset     = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [NR-1:0] mask;
      logic [PW-1:0] exp_pl, rx_pl, want_pl;
      int            g, rdly, kind, wdly, lat;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         mask = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) req_payload[i*PW +: PW] = $urandom;
         req_valid = mask;
         #1;
         g      = model_grant(mask, model_ptr);
         exp_pl = req_payload[g*PW +: PW];
         rdly   = $urandom_range(0, 3);
         kind   = (n == 0) ? 0 : $urandom_range(0, 3);
         wdly   = $urandom_range(0, 5);
         rx_pl  = $urandom;
         checks++;
         if (req_ready !== onehot(g)) begin
            failures++; $display("FAIL rand_ready[%0d]: got %b want %b", n, req_ready, onehot(g));
         end
         @(negedge clk);
         req_valid = '0;
         for (int d = 0; d < rdly; d++) begin
            #1;
            checks++;
            if (ch_tx_valid !== 1'b1 || ch_tx_tag !== TW'(g) || ch_tx_payload !== exp_pl) begin
               failures++;
               $display("FAIL rand_tx_hold[%0d]: v=%b tag=%0d pl=%h want 1/%0d/%h", n,
                        ch_tx_valid, ch_tx_tag, ch_tx_payload, g, exp_pl);
            end
            @(negedge clk);
         end
         ch_tx_ready = 1'b1;
         #1;
         checks++;
         if (ch_tx_valid !== 1'b1 || ch_tx_tag !== TW'(g) || ch_tx_payload !== exp_pl) begin
            failures++;
            $display("FAIL rand_tx[%0d]: v=%b tag=%0d pl=%h want 1/%0d/%h", n, ch_tx_valid,
                     ch_tx_tag, ch_tx_payload, g, exp_pl);
         end
         @(negedge clk);
         ch_tx_ready = 1'b0;
         if (kind == 0) begin
            lat = 0;
            for (int k = 1; k <= 40; k++) begin
               #1;
               if (rsp_valid !== '0) begin
                  lat = k;
                  break;
               end
               @(negedge clk);
            end
            checks++;
            if (lat != TO) begin
               failures++; $display("FAIL rand_timeout_lat[%0d]: got %0d want %0d", n, lat, TO);
            end
            want_pl = '0;
         end else begin
            repeat (wdly) @(negedge clk);
            if (kind == 1) begin
               ch_rx_valid   = 1'b1;
               ch_rx_tag     = TW'(g + 1);
               ch_rx_payload = ~rx_pl;
               @(negedge clk);
            end
            ch_rx_valid   = 1'b1;
            ch_rx_tag     = TW'(g);
            ch_rx_payload = rx_pl;
            @(negedge clk);
            ch_rx_valid = 1'b0;
            #1;
            want_pl = rx_pl;
         end
         checks++;
         if (rsp_valid !== onehot(g) || rsp_payload !== want_pl ||
             rsp_error !== (kind == 0)) begin
            failures++;
            $display("FAIL rand_rsp[%0d] kind=%0d: valid=%b pl=%h err=%b want %b/%h/%0d", n, kind,
                     rsp_valid, rsp_payload, rsp_error, onehot(g), want_pl, kind == 0);
         end
         model_ptr = (g + 1) % NR;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_wrong_tag();
      test_link_loss();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
